// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 2-flop sync, oversampled mid-bit sampling and a FWFT byte FIFO; optional even parity via UART_RX_PARITY_EN.
// Latency: byte pushed 1 cycle after the stop-bit mid sample, visible on o_valid/o_data the cycle after.
// Backpressure: none on the line; a push into a full FIFO without a same-cycle pop is dropped and flags overrun.
module uart_byte_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic                        UART_RX,
  input  logic                        rd_en,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  input  logic                        clear_err,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_FULL   = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [DW-1:0]   div_q, div_d;
  logic [SW-1:0]   smp_q, smp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick, mid, fe_set, pop, full, wr, ov_set;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d, parity_err_q, parity_err_d, pe_set;
`endif

  always_comb begin
    rx_meta_d = UART_RX;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    state_d   = state_q;
    div_d     = div_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_set    = 1'b0;
`endif
    tick = (state_q != IDLE) && (div_q == DIV_LAST);
    mid  = tick && (smp_q == S_MID);
    // Free-running mod-OVERSAMPLE count from the start edge keeps every later mid-bit one bit period apart.
    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) smp_d = (smp_q == S_LAST) ? '0 : smp_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (!rx_sync_q && rx_prev_q) begin
          state_d = START;
          div_d   = '0;
          smp_d   = '0;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: if (mid) state_d = rx_sync_q ? IDLE : DATA;
      DATA: begin
        if (mid) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) begin
          if (^{shift_q, rx_sync_q}) begin
            pe_set    = 1'b1;
            par_bad_d = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (mid) begin
          if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: if (rx_sync_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = rd_en && (cnt_q != '0);
    full     = (cnt_q == C_FULL);
    wr       = push_q && (!full || pop);
    ov_set   = push_q && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // clear_err wins over a same-cycle set.
    frame_err_d = clear_err ? 1'b0 : (frame_err_q | fe_set);
    overrun_d   = clear_err ? 1'b0 : (overrun_q | ov_set);
`ifdef UART_RX_PARITY_EN
    parity_err_d = clear_err ? 1'b0 : (parity_err_q | pe_set);
`endif
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_q       <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      div_q       <= div_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_valid   = (cnt_q != '0);
  assign o_data    = o_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign o_count   = cnt_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver: 2 clocks per tick, 16 ticks per bit, so one bit = 32 clocks.
module tb_uart_byte_receiver;

  localparam int BITC = 32;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       rd_en;
  logic [7:0] o_data;
  logic       o_valid;
  logic [2:0] o_count;
  logic       clear_err;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int nvec = 0;
  int nerr = 0;
  bit push_seen;

  uart_byte_receiver #(
    .CLK_FREQ(1600000), .BAUD(50000), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut (
    .sys_clock(sys_clock), .reset(reset), .UART_RX(UART_RX), .rd_en(rd_en),
    .o_data(o_data), .o_valid(o_valid), .o_count(o_count), .clear_err(clear_err),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic send_bit(input logic v);
    UART_RX = v;
    idle(BITC);
  endtask

  // stop_v = level of the stop bit; par_flip inverts the parity bit when parity is built in;
  // pop_on_push raises rd_en for exactly the cycle in which the byte is pushed.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip,
                            input logic pop_on_push);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ par_flip);
`else
    if (par_flip) UART_RX = 1'b1;
`endif
    UART_RX = stop_v;
    push_seen = 1'b0;
    for (int i = 0; i < BITC; i++) begin
      @(negedge sys_clock);
      rd_en = 1'b0;
      if (pop_on_push && !push_seen && dut.push_q) begin
        rd_en     = 1'b1;
        push_seen = 1'b1;
      end
    end
    @(negedge sys_clock);
    rd_en = 1'b0;
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    @(negedge sys_clock);
    rd_en = 1'b0;
    @(negedge sys_clock);
  endtask

  task automatic pulse_clear;
    clear_err = 1'b1;
    @(negedge sys_clock);
    clear_err = 1'b0;
    @(negedge sys_clock);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    reset = 1'b0; UART_RX = 1'b1; rd_en = 1'b0; clear_err = 1'b0;
    idle(5);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_frame", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_parity", 32'(parity_err), 32'd0);
    reset = 1'b1;
    idle(10);

    // Clean frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("a5_valid", 32'(o_valid), 32'd1);
    check("a5_data", 32'(o_data), 32'hA5);
    check("a5_count", 32'(o_count), 32'd1);
    check("a5_frame", 32'(frame_err), 32'd0);
    check("a5_overrun", 32'(overrun), 32'd0);
    pop_one();
    check("a5_pop_count", 32'(o_count), 32'd0);

    // Short low glitch, well under half a bit: false start.
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    idle(12 * BITC);
    check("glitch_valid", 32'(o_valid), 32'd0);
    check("glitch_count", 32'(o_count), 32'd0);
    check("glitch_frame", 32'(frame_err), 32'd0);

    // 0x3C with a low stop bit, then the line held low (break) for 3 more frames.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(30 * BITC);
    UART_RX = 1'b1;
    idle(3 * BITC);
    check("break_frame", 32'(frame_err), 32'd1);
    check("break_count", 32'(o_count), 32'd0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("after_break_data", 32'(o_data), 32'h11);
    check("after_break_count", 32'(o_count), 32'd1);
    pop_one();
    pulse_clear();
    check("clear_frame", 32'(frame_err), 32'd0);

    // Five bytes into a 4-deep FIFO without reading.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    idle(4);
    check("ovr_count", 32'(o_count), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), 32'(o_data), 32'(i));
      pop_one();
    end
    check("ovr_empty", 32'(o_count), 32'd0);
    pulse_clear();
    check("clear_overrun", 32'(overrun), 32'd0);

    // Full FIFO, pop coincident with the push of 0x55.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("pp_push_seen", 32'(push_seen), 32'd1);
    check("pp_count", 32'(o_count), 32'd4);
    check("pp_overrun", 32'(overrun), 32'd0);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h13; exp_bytes[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_pop%0d", i), 32'(o_data), 32'(exp_bytes[i]));
      pop_one();
    end
    check("pp_empty", 32'(o_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("par_bad_flag", 32'(parity_err), 32'd1);
    check("par_bad_count", 32'(o_count), 32'd0);
    pulse_clear();
    check("par_clear_p", 32'(parity_err), 32'd0);
    check("par_clear_f", 32'(frame_err), 32'd0);
    check("par_clear_o", 32'(overrun), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("par_good_data", 32'(o_data), 32'h07);
    check("par_good_count", 32'(o_count), 32'd1);
    pop_one();
`endif
    check("final_parity", 32'(parity_err), 32'd0);
    check("final_frame", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
